// File: rtl/key_repeat_ctrl.sv
// Purpose: turns the four-byte HID keycode word into single-cycle game-action pulses with DAS/ARR and soft-drop repeat.
// Latency: a keycode change produces its press pulse 3 Clk edges later; frame-driven repeats appear the cycle after the frame edge.
// Backpressure: none; outputs are fire-and-forget pulses and the keycode word is sampled every cycle.
module key_repeat_ctrl #(
    parameter int unsigned DAS_DELAY   = 10,
    parameter int unsigned ARR_PERIOD  = 2,
    parameter int unsigned SOFT_PERIOD = 3,
    parameter logic [7:0]  KEY_LEFT    = 8'h50,
    parameter logic [7:0]  KEY_RIGHT   = 8'h4F,
    parameter logic [7:0]  KEY_DOWN    = 8'h51,
    parameter logic [7:0]  KEY_ROT_R   = 8'h52,
    parameter logic [7:0]  KEY_ROT_L   = 8'h1D,
    parameter logic [7:0]  KEY_DROP    = 8'h2C
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] keycode,
    input  logic        frame_clk_rising_edge,
    output logic        move_left,
    output logic        move_right,
    output logic        move_down,
    output logic        rotate_left,
    output logic        rotate_right,
    output logic        hard_drop,
    output logic [5:0]  key_held
);

    localparam logic [5:0] DAS_LIM  = 6'(DAS_DELAY);
    localparam logic [5:0] ARR_LIM  = 6'(ARR_PERIOD);
    localparam logic [5:0] SOFT_LIM = 6'(SOFT_PERIOD);

    // Bit positions inside key_held / prev / press.
    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_DOWN  = 2;
    localparam int B_ROT_R = 3;
    localparam int B_ROT_L = 4;
    localparam int B_DROP  = 5;

    typedef enum logic [1:0] {
        H_IDLE,
        H_DELAY,
        H_REPEAT
    } h_state_t;

    logic [31:0] kc_q;
    logic [5:0]  held_dec;
    logic [5:0]  prev;
    logic [5:0]  press;
    logic [5:0]  soft_cnt;
    logic [5:0]  soft_inc;
    logic [5:0]  h_cnt;
    logic [5:0]  h_inc;
    logic [5:0]  h_lim;
    h_state_t    h_state;
    logic        h_dir;      // 0 = left, 1 = right
    logic        only_l;
    logic        only_r;
    logic        single;
    logic        arm;

    // A zero code is the empty-slot marker, so it must never count as a held key.
    function automatic logic has_code(input logic [31:0] kc, input logic [7:0] code);
        return (code != 8'h00) &&
               ((kc[7:0] == code) || (kc[15:8] == code) ||
                (kc[23:16] == code) || (kc[31:24] == code));
    endfunction

    // Frame counters stop at 63 instead of wrapping back through the thresholds.
    function automatic logic [5:0] sat_inc(input logic [5:0] c);
        return (c == 6'd63) ? c : c + 6'd1;
    endfunction

    // Decode which actions are present anywhere in the registered keycode word.
    always_comb begin
        held_dec         = '0;
        held_dec[B_LEFT]  = has_code(kc_q, KEY_LEFT);
        held_dec[B_RIGHT] = has_code(kc_q, KEY_RIGHT);
        held_dec[B_DOWN]  = has_code(kc_q, KEY_DOWN);
        held_dec[B_ROT_R] = has_code(kc_q, KEY_ROT_R);
        held_dec[B_ROT_L] = has_code(kc_q, KEY_ROT_L);
        held_dec[B_DROP]  = has_code(kc_q, KEY_DROP);
    end

    // Edge detection and horizontal arming conditions.
    always_comb begin
        press    = key_held & ~prev;
        soft_inc = sat_inc(soft_cnt);
        h_inc    = sat_inc(h_cnt);
        h_lim    = (h_state == H_DELAY) ? DAS_LIM : ARR_LIM;
        only_l   = key_held[B_LEFT] & ~key_held[B_RIGHT];
        only_r   = key_held[B_RIGHT] & ~key_held[B_LEFT];
        single   = only_l | only_r;
        // A fresh press, or the partner key just released, (re)starts the held direction.
        arm      = only_l ? (press[B_LEFT]  | (prev[B_RIGHT] & ~key_held[B_RIGHT]))
                          : (press[B_RIGHT] | (prev[B_LEFT]  & ~key_held[B_LEFT]));
    end

    // Stage 1: register the raw keycode word from the processor.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_q <= '0;
        end else begin
            kc_q <= keycode;
        end
    end

    // Stage 2/3: held flags, previous flags and the one-shot actions.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_held     <= '0;
            prev         <= '0;
            rotate_right <= 1'b0;
            rotate_left  <= 1'b0;
            hard_drop    <= 1'b0;
        end else begin
            key_held     <= held_dec;
            prev         <= key_held;
            rotate_right <= press[B_ROT_R];
            rotate_left  <= press[B_ROT_L];
            hard_drop    <= press[B_DROP];
        end
    end

    // Soft drop: pulse on press, then every SOFT_PERIOD frames while held.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            soft_cnt  <= '0;
            move_down <= 1'b0;
        end else begin
            move_down <= 1'b0;
            if (!key_held[B_DOWN]) begin
                soft_cnt <= '0;
            end else if (press[B_DOWN]) begin
                // The press wins over a coincident frame edge; that frame is not counted.
                move_down <= 1'b1;
                soft_cnt  <= '0;
            end else if (frame_clk_rising_edge) begin
                if (soft_inc >= SOFT_LIM) begin
                    move_down <= 1'b1;
                    soft_cnt  <= '0;
                end else begin
                    soft_cnt <= soft_inc;
                end
            end
        end
    end

    // Horizontal DAS/ARR state machine; both keys held or neither held parks it in IDLE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            h_state    <= H_IDLE;
            h_dir      <= 1'b0;
            h_cnt      <= '0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
        end else begin
            move_left  <= 1'b0;
            move_right <= 1'b0;
            if (!single) begin
                h_state <= H_IDLE;
                h_cnt   <= '0;
            end else if ((h_state == H_IDLE) || (h_dir != only_r)) begin
                // Direction not yet active: start it only on a press or re-arm event.
                h_cnt <= '0;
                if (arm) begin
                    move_left  <= only_l;
                    move_right <= only_r;
                    h_dir      <= only_r;
                    h_state    <= H_DELAY;
                end else begin
                    h_state <= H_IDLE;
                end
            end else if (frame_clk_rising_edge) begin
                if (h_inc >= h_lim) begin
                    move_left  <= ~h_dir;
                    move_right <= h_dir;
                    h_cnt      <= '0;
                    h_state    <= H_REPEAT;
                end else begin
                    h_cnt <= h_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Purpose: directed self-checking bench for key_repeat_ctrl with default DAS=10, ARR=2, SOFT=3.
// Latency: expects press pulses on the 3rd edge after a keycode change, repeats the cycle after a frame edge.
// Backpressure: none; the bench drives inputs 1 time unit after each rising edge and samples there too.
module tb_key_repeat_ctrl;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] keycode;
    logic        frame_clk_rising_edge;
    logic        move_left;
    logic        move_right;
    logic        move_down;
    logic        rotate_left;
    logic        rotate_right;
    logic        hard_drop;
    logic [5:0]  key_held;

    int n_checks = 0;
    int n_fail   = 0;
    int n_left, n_right, n_down, n_rotl, n_rotr, n_drop;

    key_repeat_ctrl dut (
        .Clk                   (Clk),
        .Reset_n               (Reset_n),
        .keycode               (keycode),
        .frame_clk_rising_edge (frame_clk_rising_edge),
        .move_left             (move_left),
        .move_right            (move_right),
        .move_down             (move_down),
        .rotate_left           (rotate_left),
        .rotate_right          (rotate_right),
        .hard_drop             (hard_drop),
        .key_held              (key_held)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [5:0] outs();
        return {hard_drop, rotate_left, rotate_right, move_down, move_right, move_left};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        n_left = 0; n_right = 0; n_down = 0; n_rotl = 0; n_rotr = 0; n_drop = 0;
    endtask

    // One clock; every cycle is sampled exactly once so pulse counts are exact.
    task automatic tick();
        @(posedge Clk);
        #1;
        n_left  += int'(move_left);
        n_right += int'(move_right);
        n_down  += int'(move_down);
        n_rotl  += int'(rotate_left);
        n_rotr  += int'(rotate_right);
        n_drop  += int'(hard_drop);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Frame pulse high for exactly one sampling edge; outputs observed right after it.
    task automatic frame_tick();
        frame_clk_rising_edge = 1'b1;
        tick();
        frame_clk_rising_edge = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0;
        keycode = 32'h0000_0050;
        frame_clk_rising_edge = 1'b0;
        clr_counts();

        // 1: reset state, then a press of a key already held during reset
        ticks(2);
        check("reset_outs", outs(), 6'h00);
        check("reset_held", key_held, 6'h00);
        Reset_n = 1'b1;
        tick();
        check("rel_e1", outs(), 6'h00);
        tick();
        check("rel_e2", outs(), 6'h00);
        tick();
        check("rel_e3_left", outs(), 6'b000001);
        check("rel_held", key_held, 6'b000001);
        tick();
        check("rel_e4", outs(), 6'h00);
        keycode = 32'h0;
        ticks(4);

        // 2: right in byte 2, DAS then ARR over 20 frames
        clr_counts();
        keycode = 32'h004F_0000;
        ticks(2);
        check("r_press_e2", move_right, 1'b0);
        tick();
        check("r_press_e3", move_right, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            frame_tick();
            check($sformatf("r_frame%0d", i), move_right, (i >= 10 && i % 2 == 0));
            tick();
        end
        check("r_total", n_right, 7);
        keycode = 32'h0;
        ticks(3);
        for (int i = 0; i < 5; i++) begin
            frame_tick();
            tick();
        end
        check("r_after_release", n_right, 7);

        // 3: rotate right fires once, moving byte slot is not a new press
        clr_counts();
        keycode = 32'h0000_0052;
        ticks(3);
        check("rotr_press", rotate_right, 1'b1);
        for (int i = 0; i < 30; i++) frame_tick();
        check("rotr_once", n_rotr, 1);
        keycode = 32'h0000_5200;
        ticks(5);
        check("rotr_moved", n_rotr, 1);

        // Reset mid-hold clears asynchronously and re-presses afterwards
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("arst_held", key_held, 6'h00);
        check("arst_outs", outs(), 6'h00);
        tick();
        Reset_n = 1'b1;
        clr_counts();
        ticks(2);
        check("rearm_e2", rotate_right, 1'b0);
        tick();
        check("rearm_e3", rotate_right, 1'b1);
        keycode = 32'h0;
        ticks(4);

        // 4: left+right together suppresses, releasing left re-arms right
        keycode = 32'h0000_0050;
        ticks(3);
        check("lr_left_press", move_left, 1'b1);
        clr_counts();
        for (int i = 1; i <= 4; i++) begin
            frame_tick();
            tick();
        end
        keycode = 32'h0000_4F50;
        ticks(3);
        for (int i = 5; i <= 7; i++) begin
            frame_tick();
            tick();
        end
        check("lr_both_left", n_left, 0);
        check("lr_both_right", n_right, 0);
        keycode = 32'h0000_004F;
        ticks(2);
        check("lr_held_right", key_held, 6'b000010);
        check("lr_not_yet", move_right, 1'b0);
        tick();
        check("lr_rearm", move_right, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            frame_tick();
            tick();
        end
        check("lr_das_wait", n_right, 1);
        frame_tick();
        check("lr_das_fire", move_right, 1'b1);
        check("lr_left_quiet", n_left, 0);
        keycode = 32'h0;
        ticks(4);

        // 5: four simultaneous actions, soft drop repeats every 3 frames
        clr_counts();
        keycode = 32'h2C1D_5150;
        ticks(3);
        check("multi_outs", outs(), 6'b110101);
        check("multi_held", key_held, 6'b110101);
        for (int i = 1; i <= 6; i++) begin
            frame_tick();
            check($sformatf("down_f%0d", i), move_down, (i % 3 == 0));
            check($sformatf("left_f%0d", i), move_left, 1'b0);
            tick();
        end
        check("multi_down_total", n_down, 3);
        check("multi_left_total", n_left, 1);
        check("multi_drop_total", n_drop, 1);
        check("multi_rotl_total", n_rotl, 1);
        keycode = 32'h0;
        ticks(4);

        // 6: press coincides with frame edge; frame not counted toward DAS
        clr_counts();
        keycode = 32'h0000_0050;
        ticks(2);
        frame_tick();
        check("coinc_press", move_left, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            frame_tick();
            tick();
        end
        check("coinc_wait", n_left, 1);
        frame_tick();
        check("coinc_das", move_left, 1'b1);
        keycode = 32'h0;
        ticks(4);

        // Duplicate code across bytes is a single key
        clr_counts();
        keycode = 32'h2C2C_002C;
        ticks(3);
        check("dup_press", hard_drop, 1'b1);
        ticks(5);
        check("dup_once", n_drop, 1);
        keycode = 32'h0;
        ticks(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
